// File: rtl/tone_sweep_sequencer.sv
// Tone sweep sequencer: steps a small table of freq/waveform/dwell entries
// and feeds the CORDIC tone generator, once or looping.
module tone_sweep_sequencer #(
  parameter int FREQ_WIDTH  = 12,
  parameter int IDX_WIDTH   = 3,
  parameter int DWELL_WIDTH = 8,
  parameter int TICK_DIV    = 131072,
  parameter int TICK_WIDTH  = 17
) (
  input  logic                   clk1,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_en,
  input  logic [IDX_WIDTH-1:0]   num_entries,
  input  logic                   wr_en,
  input  logic [IDX_WIDTH-1:0]   wr_addr,
  input  logic [FREQ_WIDTH-1:0]  wr_freq,
  input  logic                   wr_sel,
  input  logic [DWELL_WIDTH-1:0] wr_dwell,
  output logic [FREQ_WIDTH-1:0]  freq,
  output logic                   waveform_sel,
  output logic                   freq_valid,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_WIDTH-1:0]   cur_index
);

  localparam int DEPTH = 2 ** IDX_WIDTH;
  localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(TICK_DIV - 1);
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    DONE
  } state_t;

  state_t                 state;
  logic [FREQ_WIDTH-1:0]  tbl_freq  [DEPTH];
  logic                   tbl_sel   [DEPTH];
  logic [DWELL_WIDTH-1:0] tbl_dwell [DEPTH];
  logic [IDX_WIDTH-1:0]   last_idx;
  logic [TICK_WIDTH-1:0]  prescale;
  logic [DWELL_WIDTH-1:0] dwell_cnt;
  logic [DWELL_WIDTH-1:0] ld_dwell;

  assign ld_dwell = tbl_dwell[cur_index];

  always_ff @(posedge clk1) begin
    if (reset) begin
      state        <= IDLE;
      freq         <= '0;
      waveform_sel <= 1'b0;
      freq_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cur_index    <= '0;
      last_idx     <= '0;
      prescale     <= '0;
      dwell_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_freq[i]  <= '0;
        tbl_sel[i]   <= 1'b0;
        tbl_dwell[i] <= '0;
      end
    end else begin
      freq_valid <= 1'b0;
      done       <= 1'b0;
      // LOAD below samples the pre-write contents on a same-address hit
      if (wr_en) begin
        tbl_freq[wr_addr]  <= wr_freq;
        tbl_sel[wr_addr]   <= wr_sel;
        tbl_dwell[wr_addr] <= wr_dwell;
      end
      if (stop) begin
        state <= IDLE;
        freq  <= '0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state     <= LOAD;
              cur_index <= '0;
              last_idx  <= num_entries;
              busy      <= 1'b1;
            end
          end
          LOAD: begin
            freq         <= tbl_freq[cur_index];
            waveform_sel <= tbl_sel[cur_index];
            dwell_cnt    <= (ld_dwell == '0) ? DWELL_ONE : ld_dwell;
            prescale     <= '0;
            freq_valid   <= 1'b1;
            state        <= PLAY;
          end
          PLAY: begin
            if (prescale == TICK_LAST) begin
              prescale  <= '0;
              dwell_cnt <= dwell_cnt - DWELL_ONE;
              if (dwell_cnt == DWELL_ONE) begin
                if (cur_index != last_idx) begin
                  cur_index <= cur_index + 1'b1;
                  state     <= LOAD;
                end else if (loop_en) begin
                  cur_index <= '0;
                  state     <= LOAD;
                end else begin
                  state <= DONE;
                  busy  <= 1'b0;
                end
              end
            end else begin
              prescale <= prescale + 1'b1;
            end
          end
          DONE: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_sweep_sequencer.sv
// Directed bench for tone_sweep_sequencer with a 4-cycle tick.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_tone_sweep_sequencer;

  localparam int FW = 12;
  localparam int IW = 3;
  localparam int DW = 8;

  logic          clk1 = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [IW-1:0] num_entries;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [FW-1:0] wr_freq;
  logic          wr_sel;
  logic [DW-1:0] wr_dwell;
  logic [FW-1:0] freq;
  logic          waveform_sel;
  logic          freq_valid;
  logic          busy;
  logic          done;
  logic [IW-1:0] cur_index;

  int n_checks = 0;
  int n_fail   = 0;
  logic saw_done;

  tone_sweep_sequencer #(
    .FREQ_WIDTH (FW),
    .IDX_WIDTH  (IW),
    .DWELL_WIDTH(DW),
    .TICK_DIV   (4),
    .TICK_WIDTH (2)
  ) dut (
    .clk1        (clk1),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .num_entries (num_entries),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_freq     (wr_freq),
    .wr_sel      (wr_sel),
    .wr_dwell    (wr_dwell),
    .freq        (freq),
    .waveform_sel(waveform_sel),
    .freq_valid  (freq_valid),
    .busy        (busy),
    .done        (done),
    .cur_index   (cur_index)
  );

  always #5 clk1 = ~clk1;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [IW-1:0] a, input logic [FW-1:0] f,
                    input logic s, input logic [DW-1:0] d);
    wr_en    = 1'b1;
    wr_addr  = a;
    wr_freq  = f;
    wr_sel   = s;
    wr_dwell = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    loop_en     = 1'b0;
    num_entries = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_freq     = '0;
    wr_sel      = 1'b0;
    wr_dwell    = '0;
    step(2);
    reset = 1'b0;
    chk("rst_freq", 32'(freq), 0);
    chk("rst_sel", 32'(waveform_sel), 0);
    chk("rst_fv", 32'(freq_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_idx", 32'(cur_index), 0);

    // single pass over two entries
    wr(0, 100, 1'b0, 2);
    wr(1, 4095, 1'b1, 1);
    num_entries = 1;
    loop_en     = 1'b0;
    pulse_start();
    chk("s1_load_busy", 32'(busy), 1);
    chk("s1_load_fv", 32'(freq_valid), 0);
    step();
    chk("s1_e0_fv", 32'(freq_valid), 1);
    chk("s1_e0_freq", 32'(freq), 100);
    chk("s1_e0_sel", 32'(waveform_sel), 0);
    chk("s1_e0_idx", 32'(cur_index), 0);
    step(8);
    chk("s1_pre_e1_fv", 32'(freq_valid), 0);
    step();
    chk("s1_e1_fv", 32'(freq_valid), 1);
    chk("s1_e1_freq", 32'(freq), 4095);
    chk("s1_e1_sel", 32'(waveform_sel), 1);
    chk("s1_e1_idx", 32'(cur_index), 1);
    step(4);
    chk("s1_donest_done", 32'(done), 0);
    chk("s1_donest_busy", 32'(busy), 0);
    step();
    chk("s1_done", 32'(done), 1);
    chk("s1_done_fv", 32'(freq_valid), 0);
    chk("s1_done_busy", 32'(busy), 0);
    chk("s1_hold_freq", 32'(freq), 4095);
    step();
    chk("s1_done_pulse", 32'(done), 0);

    // looping playback, then drop loop_en
    loop_en = 1'b1;
    pulse_start();
    step();
    chk("s2_e0_freq", 32'(freq), 100);
    step(9);
    chk("s2_e1_fv", 32'(freq_valid), 1);
    chk("s2_e1_freq", 32'(freq), 4095);
    step(5);
    chk("s2_wrap_fv", 32'(freq_valid), 1);
    chk("s2_wrap_freq", 32'(freq), 100);
    chk("s2_wrap_idx", 32'(cur_index), 0);
    chk("s2_wrap_nodone", 32'(done), 0);
    chk("s2_wrap_busy", 32'(busy), 1);
    step(9);
    chk("s2_e1b_freq", 32'(freq), 4095);
    loop_en = 1'b0;
    step(5);
    chk("s2_end_done", 32'(done), 1);
    chk("s2_end_busy", 32'(busy), 0);

    // dwell of zero plays as one tick
    wr(0, 200, 1'b1, 0);
    num_entries = 0;
    loop_en     = 1'b1;
    pulse_start();
    step();
    chk("s3_fv", 32'(freq_valid), 1);
    chk("s3_freq", 32'(freq), 200);
    chk("s3_sel", 32'(waveform_sel), 1);
    step(4);
    chk("s3_mid_fv", 32'(freq_valid), 0);
    step();
    chk("s3_period_fv", 32'(freq_valid), 1);
    chk("s3_period_freq", 32'(freq), 200);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("s3_stop_busy", 32'(busy), 0);
    chk("s3_stop_freq", 32'(freq), 0);

    // stop together with start in the middle of entry 1
    wr(0, 100, 1'b0, 2);
    num_entries = 1;
    loop_en     = 1'b0;
    pulse_start();
    step();
    chk("s4_e0_freq", 32'(freq), 100);
    step(9);
    chk("s4_e1_freq", 32'(freq), 4095);
    step(2);
    stop  = 1'b1;
    start = 1'b1;
    step();
    stop  = 1'b0;
    start = 1'b0;
    chk("s4_stop_busy", 32'(busy), 0);
    chk("s4_stop_freq", 32'(freq), 0);
    chk("s4_stop_sel", 32'(waveform_sel), 1);
    chk("s4_stop_idx", 32'(cur_index), 1);
    chk("s4_stop_done", 32'(done), 0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      saw_done = saw_done | done | busy;
    end
    chk("s4_idle_quiet", 32'(saw_done), 0);
    pulse_start();
    step();
    chk("s4_restart_fv", 32'(freq_valid), 1);
    chk("s4_restart_freq", 32'(freq), 100);
    chk("s4_restart_idx", 32'(cur_index), 0);

    // rewrite entry 0 while it plays
    loop_en = 1'b1;
    wr(0, 300, 1'b0, 2);
    chk("s5_unchanged", 32'(freq), 100);
    step(8);
    chk("s5_e1_fv", 32'(freq_valid), 1);
    chk("s5_e1_freq", 32'(freq), 4095);
    step(5);
    chk("s5_reload_fv", 32'(freq_valid), 1);
    chk("s5_reload_freq", 32'(freq), 300);

    // reset in the middle of playback
    step(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s6_rst_freq", 32'(freq), 0);
    chk("s6_rst_sel", 32'(waveform_sel), 0);
    chk("s6_rst_busy", 32'(busy), 0);
    chk("s6_rst_done", 32'(done), 0);
    chk("s6_rst_idx", 32'(cur_index), 0);
    chk("s6_rst_fv", 32'(freq_valid), 0);
    loop_en = 1'b0;
    pulse_start();
    step();
    chk("s6_run_fv", 32'(freq_valid), 1);
    chk("s6_run_freq", 32'(freq), 0);
    step(5);
    chk("s6_e1_fv", 32'(freq_valid), 1);
    chk("s6_e1_sel", 32'(waveform_sel), 0);
    chk("s6_e1_idx", 32'(cur_index), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
